// File: rtl/logic_gate_array.sv
// N_IN-input, WIDTH-bit bitwise gate unit with a registered valid/ready output
// stage and a built-in sweep FSM that streams the full truth table through the gate.
module logic_gate_array #(
  parameter int N_IN  = 2,
  parameter int WIDTH = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [2:0]              op,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [N_IN*WIDTH-1:0]   in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_err,
  output logic [N_IN-1:0]         out_tag,
  input  logic                    sweep_start,
  output logic                    sweep_busy,
  output logic                    sweep_done
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  localparam logic [N_IN:0] LAST_PAT = {1'b0, {N_IN{1'b1}}};
  localparam logic [N_IN:0] CNT_ONE  = {{N_IN{1'b0}}, 1'b1};

  state_t                  state;
  logic [2:0]              sweep_op;
  logic [N_IN:0]           cnt;
  logic [N_IN*WIDTH-1:0]   sweep_data;
  logic [WIDTH:0]          ext_result;
  logic [WIDTH:0]          sweep_result;
  logic                    out_free;
  logic                    ext_load;
  logic                    sweep_load;

  // Result is {err, data}; NOT looks at lane 0 only, illegal ops yield zero data.
  function automatic logic [WIDTH:0] gate_eval(input logic [2:0] f_op,
                                               input logic [N_IN*WIDTH-1:0] d);
    logic [WIDTH-1:0] r_and;
    logic [WIDTH-1:0] r_or;
    logic [WIDTH-1:0] r_xor;
    logic [WIDTH-1:0] lane;
    r_and = '1;
    r_or  = '0;
    r_xor = '0;
    for (int k = 0; k < N_IN; k++) begin
      lane  = d[k*WIDTH +: WIDTH];
      r_and = r_and & lane;
      r_or  = r_or | lane;
      r_xor = r_xor ^ lane;
    end
    case (f_op)
      3'b000:  gate_eval = {1'b0, ~r_and};
      3'b001:  gate_eval = {1'b0, ~r_or};
      3'b010:  gate_eval = {1'b0, ~d[WIDTH-1:0]};
      3'b011:  gate_eval = {1'b0, r_and};
      3'b100:  gate_eval = {1'b0, r_or};
      3'b101:  gate_eval = {1'b0, r_xor};
      default: gate_eval = {1'b1, {WIDTH{1'b0}}};
    endcase
  endfunction

  assign out_free   = !out_valid || out_ready;
  assign in_ready   = rst_n && (state == IDLE) && !sweep_start && out_free;
  assign ext_load   = in_valid && in_ready;
  assign sweep_load = (state == RUN) && out_free;

  always_comb begin
    sweep_data = '0;
    for (int k = 0; k < N_IN; k++) begin
      sweep_data[k*WIDTH +: WIDTH] = {WIDTH{cnt[k]}};
    end
  end

  always_comb begin
    ext_result   = gate_eval(op, in_data);
    sweep_result = gate_eval(sweep_op, sweep_data);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      sweep_op   <= 3'b000;
      cnt        <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_err    <= 1'b0;
      out_tag    <= '0;
      sweep_busy <= 1'b0;
      sweep_done <= 1'b0;
    end else begin
      sweep_done <= 1'b0;

      if (ext_load) begin
        out_valid           <= 1'b1;
        {out_err, out_data} <= ext_result;
        out_tag             <= '0;
      end else if (sweep_load) begin
        out_valid           <= 1'b1;
        {out_err, out_data} <= sweep_result;
        out_tag             <= cnt[N_IN-1:0];
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end

      // DRAIN holds until the last pattern has left the output register.
      case (state)
        IDLE: begin
          if (sweep_start) begin
            state      <= RUN;
            sweep_op   <= op;
            cnt        <= '0;
            sweep_busy <= 1'b1;
          end
        end
        RUN: begin
          if (sweep_load) begin
            cnt <= cnt + CNT_ONE;
            if (cnt == LAST_PAT) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (out_valid && out_ready) begin
            state      <= DONE;
            sweep_done <= 1'b1;
          end
        end
        DONE: begin
          state      <= IDLE;
          cnt        <= '0;
          sweep_busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
